// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and encodings for the unified memory port arbiter:
//   FSM state encoding, DMwidth codes, transaction owner codes, byte-lane
//   geometry and the latched transaction payload.
package mem_port_arbiter_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DATA_W    = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_LS = 1'b1
  } arb_own_e;

  // DMwidth codes; 2'b11 is illegal and rejected with ls_err
  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  // Everything the port needs after the grant: the store side is already
  // encoded (be/wdata), the load side keeps what extract/extend needs.
  typedef struct packed {
    logic                 we;
    logic                 uns;
    logic [1:0]           width;
    logic [1:0]           off;
    logic [NUM_LANES-1:0] be;
    logic [DATA_W-1:0]    wdata;
  } arb_pay_t;

  function automatic logic ls_illegal(input logic [1:0] width, input logic [1:0] off);
    return (width == 2'b11) ||
           (width == MEM_W_HALF && off[0]) ||
           (width == MEM_W_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// lsu_align
//   Purely combinational load/store lane logic for mem_port_arbiter.
//   Request side (live ls_* inputs, used in IDLE):
//     rq_we_i, rq_width_i, rq_off_i, rq_wdata_i -> rq_err_o, rq_be_o, rq_wdata_o
//   Load side (latched payload + memory word):
//     ld_width_i, ld_off_i, ld_uns_i, ld_rdata_i -> ld_data_o
module lsu_align
  import mem_port_arbiter_pkg::*;
(
  input  logic                 rq_we_i,
  input  logic [1:0]           rq_width_i,
  input  logic [1:0]           rq_off_i,
  input  logic [DATA_W-1:0]    rq_wdata_i,
  output logic                 rq_err_o,
  output logic [NUM_LANES-1:0] rq_be_o,
  output logic [DATA_W-1:0]    rq_wdata_o,
  input  logic [1:0]           ld_width_i,
  input  logic [1:0]           ld_off_i,
  input  logic                 ld_uns_i,
  input  logic [DATA_W-1:0]    ld_rdata_i,
  output logic [DATA_W-1:0]    ld_data_o
);

  logic [NUM_LANES-1:0][LANE_W-1:0] wd_in, wd_out, rd_in;
  logic [LANE_W-1:0]                ld_byte;
  logic [2*LANE_W-1:0]              ld_half;

  assign wd_in      = rq_wdata_i;
  assign rd_in      = ld_rdata_i;
  assign rq_wdata_o = wd_out;
  assign rq_err_o   = ls_illegal(rq_width_i, rq_off_i);

  // Per byte lane: enable and replicated store data. Loads enable all lanes
  // and carry no write data.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic sel;
    assign sel = (rq_width_i == MEM_W_WORD) ||
                 (rq_width_i == MEM_W_HALF && rq_off_i[1] == LANE[1]) ||
                 (rq_width_i == MEM_W_BYTE && rq_off_i == LANE);
    assign rq_be_o[k] = !rq_we_i || sel;
    assign wd_out[k]  = !rq_we_i                  ? '0 :
                        (rq_width_i == MEM_W_BYTE) ? wd_in[0] :
                        (rq_width_i == MEM_W_HALF) ? wd_in[k % 2] :
                                                     wd_in[k];
  end

  assign ld_byte = rd_in[ld_off_i];
  assign ld_half = ld_off_i[1] ? {rd_in[3], rd_in[2]} : {rd_in[1], rd_in[0]};

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_width_i)
      MEM_W_BYTE: ld_data_o = {{(DATA_W-LANE_W){!ld_uns_i && ld_byte[LANE_W-1]}}, ld_byte};
      MEM_W_HALF: ld_data_o = {{(DATA_W-2*LANE_W){!ld_uns_i && ld_half[2*LANE_W-1]}}, ld_half};
      default:    ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and load/store (LS)
//   with a single outstanding transaction. IDLE grants combinationally,
//   ISSUE holds mem_req with the latched payload until mem_gnt, WAIT returns
//   the response to the owner on mem_rvalid.
//   Ports: clk_i, rst_ni (async, active low)
//     IF : if_req_i, if_addr_i -> if_gnt_o, if_rvalid_o, if_rdata_o
//     LS : ls_req_i, ls_we_i, ls_unsigned_i, ls_width_i, ls_addr_i, ls_wdata_i
//          -> ls_gnt_o, ls_err_o, ls_rvalid_o, ls_rdata_o
//     MEM: mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
//          <- mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   Optional: MEM_ARB_STARVE_EN gives IF the port after STARVE_MAX
//   consecutive LS grants made while IF was waiting; default is strict LS
//   priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 if_req_i,
  input  logic [ADDR_W-1:0]    if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [DATA_W-1:0]    if_rdata_o,
  input  logic                 ls_req_i,
  input  logic                 ls_we_i,
  input  logic                 ls_unsigned_i,
  input  logic [1:0]           ls_width_i,
  input  logic [ADDR_W-1:0]    ls_addr_i,
  input  logic [DATA_W-1:0]    ls_wdata_i,
  output logic                 ls_gnt_o,
  output logic                 ls_err_o,
  output logic                 ls_rvalid_o,
  output logic [DATA_W-1:0]    ls_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [NUM_LANES-1:0] mem_be_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DATA_W-1:0]    mem_rdata_i
);

  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_e          state_q, state_d;
  arb_own_e            own_q, own_d;
  arb_pay_t            pay_q, pay_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;   // word address only

  logic                ls_bad;
  logic [NUM_LANES-1:0] ls_be;
  logic [DATA_W-1:0]   ls_wdata_enc, ld_data;
  logic                if_wins;

  lsu_align u_align (
    .rq_we_i    (ls_we_i),
    .rq_width_i (ls_width_i),
    .rq_off_i   (ls_addr_i[1:0]),
    .rq_wdata_i (ls_wdata_i),
    .rq_err_o   (ls_bad),
    .rq_be_o    (ls_be),
    .rq_wdata_o (ls_wdata_enc),
    .ld_width_i (pay_q.width),
    .ld_off_i   (pay_q.off),
    .ld_uns_i   (pay_q.uns),
    .ld_rdata_i (mem_rdata_i),
    .ld_data_o  (ld_data)
  );

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign if_wins = (starve_q == CNT_W'(STARVE_MAX)) && if_req_i && ls_req_i;

  // Counts LS grants that overtook a waiting fetch; any IF grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt_o)
      starve_d = '0;
    else if (ls_gnt_o && if_req_i && starve_q != CNT_W'(STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  assign if_wins = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    pay_d       = pay_q;
    waddr_d     = waddr_q;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_gnt_o    = 1'b0;
    ls_err_o    = 1'b0;
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (state_q)
      ARB_IDLE: begin
        // Grants are combinational from the requests, so gate them with the
        // reset input to keep every output low while reset is held.
        if (rst_ni) begin
          if (ls_req_i && !if_wins) begin
            // A rejected access still owns this cycle: IF waits for the next.
            if (ls_bad) begin
              ls_err_o = 1'b1;
            end else begin
              ls_gnt_o = 1'b1;
              own_d    = ARB_OWN_LS;
              waddr_d  = ls_addr_i[ADDR_W-1:2];
              pay_d    = '{we: ls_we_i, uns: ls_unsigned_i, width: ls_width_i,
                           off: ls_addr_i[1:0], be: ls_be, wdata: ls_wdata_enc};
              state_d  = ARB_ISSUE;
            end
          end else if (if_req_i) begin
            if_gnt_o = 1'b1;
            own_d    = ARB_OWN_IF;
            waddr_d  = if_addr_i[ADDR_W-1:2];
            pay_d    = '{we: 1'b0, uns: 1'b0, width: MEM_W_WORD,
                         off: if_addr_i[1:0], be: '1, wdata: '0};
            state_d  = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = pay_q.we;
        mem_addr_o  = {waddr_q, 2'b00};
        mem_be_o    = pay_q.be;
        mem_wdata_o = pay_q.wdata;
        if (mem_gnt_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = ARB_IDLE;
          if (own_q == ARB_OWN_LS) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = pay_q.we ? '0 : ld_data;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      own_q   <= ARB_OWN_IF;
      pay_q   <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      pay_q   <= pay_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_unsigned, ls_gnt, ls_err, ls_rvalid;
  logic [1:0]  ls_width;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] ls_q[$];
  logic [31:0] if_q[$];
  logic        own_q[$];   // 1 = LS, 0 = IF

  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] mem_word  = 32'h0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_unsigned_i(ls_unsigned),
    .ls_width_i(ls_width), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_err_o(ls_err), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: grants after gnt_delay waiting cycles, responds rv_delay
  // cycles after the cycle following the grant. Shares rst_n.
  initial begin
    int wcnt, rv_cnt;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; wcnt = 0; rv_cnt = -1;
    forever begin
      @(negedge clk);
      mem_rvalid = 0; mem_rdata = '0;
      if (!rst_n) begin
        mem_gnt = 0; wcnt = 0; rv_cnt = -1;
      end else begin
        if (mem_gnt) begin
          mem_gnt = 0; rv_cnt = rv_delay;
        end else if (mem_req && rv_cnt < 0) begin
          if (wcnt >= gnt_delay) begin mem_gnt = 1; wcnt = 0; end
          else wcnt++;
        end
        if (rv_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = mem_word; rv_cnt = -1;
        end else if (rv_cnt > 0) rv_cnt--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input bit ls, output bit seen);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (ls ? ls_rvalid : if_rvalid) begin seen = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 0; if_req = 1; if_addr = 32'h40; ls_req = 1; ls_we = 0; ls_unsigned = 0;
    ls_width = 2'b10; ls_addr = 32'h100; ls_wdata = '0;
    step(); step();
    checks++;
    if ({if_gnt, if_rvalid, ls_gnt, ls_err, ls_rvalid} !== 5'b0)
      begin errors++; $display("FAIL reset_hs got=%b exp=00000", {if_gnt, if_rvalid, ls_gnt, ls_err, ls_rvalid}); end
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0)
      begin errors++; $display("FAIL reset_mem req=%b be=%h addr=%h exp=0", mem_req, mem_be, mem_addr); end
    checks++;
    if ({if_rdata, ls_rdata} !== '0)
      begin errors++; $display("FAIL reset_rdata if=%h ls=%h exp=0", if_rdata, ls_rdata); end
    if_req = 0; ls_req = 0;
    rst_n = 1;
    step();
  endtask

  task automatic test_load_path();
    logic [31:0] t_addr [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h104};
    logic [1:0]  t_w    [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    logic        t_u    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                32'h0000_1234, 32'h0000_0012, 32'h80FF_1234};
    logic [31:0] exp_addr, got;
    gnt_delay = 0; rv_delay = 0; mem_word = 32'h80FF_1234;
    for (int i = 0; i < 7; i++) begin
      ls_req = 1; ls_we = 0; ls_unsigned = t_u[i]; ls_width = t_w[i];
      ls_addr = t_addr[i]; ls_wdata = 32'h5555_5555;
      exp_addr = {t_addr[i][31:2], 2'b00};
      #1;
      checks++;
      if (ls_gnt !== 1'b1 || ls_err !== 1'b0)
        begin errors++; $display("FAIL load_gnt[%0d] gnt=%b err=%b exp=1/0", i, ls_gnt, ls_err); end
      ls_q.push_back(t_exp[i]);
      step();
      // inputs are only sampled in IDLE: scramble them after the grant
      ls_req = 0; ls_addr = 32'hFFFF_FFFF; ls_width = 2'b11; ls_unsigned = ~t_u[i];
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_be !== 4'hF || mem_we !== 1'b0)
        begin errors++; $display("FAIL load_issue[%0d] req=%b addr=%h be=%h we=%b exp=1 %h f 0", i, mem_req, mem_addr, mem_be, mem_we, exp_addr); end
      step();
      checks++;
      got = ls_q.pop_front();
      if (ls_rvalid !== 1'b1 || ls_rdata !== got)
        begin errors++; $display("FAIL load_rdata[%0d] rvalid=%b got=%h exp=%h", i, ls_rvalid, ls_rdata, got); end
      step();
      checks++;
      if (ls_rvalid !== 1'b0 || mem_req !== 1'b0)
        begin errors++; $display("FAIL load_pulse[%0d] rvalid=%b req=%b exp=0 0", i, ls_rvalid, mem_req); end
    end
  endtask

  task automatic test_store_path();
    logic [31:0] t_addr [3] = '{32'h206, 32'h301, 32'h308};
    logic [1:0]  t_w    [3] = '{2'b01, 2'b00, 2'b10};
    logic [31:0] t_wd   [3] = '{32'h0000_ABCD, 32'h0000_005A, 32'h1234_5678};
    logic [3:0]  t_be   [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] t_mwd  [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1234_5678};
    logic [31:0] exp_addr, got;
    bit seen;
    gnt_delay = 0; rv_delay = 1; mem_word = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      ls_req = 1; ls_we = 1; ls_unsigned = 0; ls_width = t_w[i];
      ls_addr = t_addr[i]; ls_wdata = t_wd[i];
      exp_addr = {t_addr[i][31:2], 2'b00};
      #1;
      checks++;
      if (ls_gnt !== 1'b1)
        begin errors++; $display("FAIL store_gnt[%0d] got=%b exp=1", i, ls_gnt); end
      ls_q.push_back(32'h0);
      step();
      ls_req = 0; ls_wdata = 32'h1111_1111; ls_we = 0;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr ||
          mem_be !== t_be[i] || mem_wdata !== t_mwd[i])
        begin errors++; $display("FAIL store_issue[%0d] we=%b addr=%h be=%b wd=%h exp=1 %h %b %h", i, mem_we, mem_addr, mem_be, mem_wdata, exp_addr, t_be[i], t_mwd[i]); end
      wait_rvalid(1, seen);
      checks++;
      got = ls_q.pop_front();
      if (!seen || ls_rdata !== got)
        begin errors++; $display("FAIL store_ack[%0d] seen=%b got=%h exp=%h", i, seen, ls_rdata, got); end
      step();
    end
    rv_delay = 0;
  endtask

  task automatic test_misaligned();
    logic [31:0] t_addr [4] = '{32'h302, 32'h301, 32'h303, 32'h100};
    logic [1:0]  t_w    [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] got;
    bit seen;
    mem_word = 32'h0000_0093;
    for (int i = 0; i < 4; i++) begin
      ls_req = 1; ls_we = 0; ls_width = t_w[i]; ls_addr = t_addr[i];
      if_req = (i == 3); if_addr = 32'h40;
      #1;
      checks++;
      if (ls_err !== 1'b1 || ls_gnt !== 1'b0 || if_gnt !== 1'b0)
        begin errors++; $display("FAIL misalign_err[%0d] err=%b gnt=%b ifgnt=%b exp=1 0 0", i, ls_err, ls_gnt, if_gnt); end
      step();
      ls_req = 0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || ls_err !== 1'b0)
        begin errors++; $display("FAIL misalign_noissue[%0d] req=%b err=%b exp=0 0", i, mem_req, ls_err); end
    end
    // the fetch that waited behind the rejected access goes next
    checks++;
    if (if_gnt !== 1'b1)
      begin errors++; $display("FAIL fetch_after_err got=%b exp=1", if_gnt); end
    if_q.push_back(32'h0000_0093);
    step();
    if_req = 0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_be !== 4'hF || mem_we !== 1'b0)
      begin errors++; $display("FAIL fetch_issue req=%b addr=%h be=%h we=%b exp=1 40 f 0", mem_req, mem_addr, mem_be, mem_we); end
    wait_rvalid(0, seen);
    checks++;
    got = if_q.pop_front();
    if (!seen || if_rdata !== got)
      begin errors++; $display("FAIL fetch_rdata seen=%b got=%h exp=%h", seen, if_rdata, got); end
    step();
  endtask

  task automatic test_contention();
    logic [31:0] got;
    bit seen;
    gnt_delay = 3; rv_delay = 0; mem_word = 32'h0BAD_F00D;
    ls_req = 1; ls_we = 0; ls_width = 2'b10; ls_addr = 32'h400; if_req = 1; if_addr = 32'h80;
    #1;
    checks++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0)
      begin errors++; $display("FAIL contend_prio ls=%b if=%b exp=1 0", ls_gnt, if_gnt); end
    ls_q.push_back(32'h0BAD_F00D);
    step();
    ls_req = 0; ls_addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_be !== 4'hF || mem_we !== 1'b0 || if_gnt !== 1'b0)
        begin errors++; $display("FAIL contend_hold[%0d] req=%b addr=%h be=%h ifgnt=%b exp=1 400 f 0", k, mem_req, mem_addr, mem_be, if_gnt); end
      step();
    end
    checks++;
    got = ls_q.pop_front();
    if (ls_rvalid !== 1'b1 || ls_rdata !== got || if_gnt !== 1'b0)
      begin errors++; $display("FAIL contend_rvalid rv=%b got=%h exp=%h ifgnt=%b", ls_rvalid, ls_rdata, got, if_gnt); end
    mem_word = 32'h0000_0013;
    step();
    checks++;
    if (if_gnt !== 1'b1)
      begin errors++; $display("FAIL back_to_back_ifgnt got=%b exp=1", if_gnt); end
    if_q.push_back(32'h0000_0013);
    step();
    if_req = 0;
    wait_rvalid(0, seen);
    checks++;
    got = if_q.pop_front();
    if (!seen || if_rdata !== got)
      begin errors++; $display("FAIL contend_fetch seen=%b got=%h exp=%h", seen, if_rdata, got); end
    step();
    gnt_delay = 0;
  endtask

  task automatic test_reset_midop();
    bit spurious;
    gnt_delay = 0; rv_delay = 3; mem_word = 32'h7777_7777;
    ls_req = 1; ls_we = 0; ls_width = 2'b10; ls_addr = 32'h500;
    #1;
    step();
    ls_req = 0;
    step(); step();
    checks++;
    if (mem_req !== 1'b0 || ls_rvalid !== 1'b0)
      begin errors++; $display("FAIL midop_wait req=%b rv=%b exp=0 0", mem_req, ls_rvalid); end
    ls_req = 1; if_req = 1; if_addr = 32'h80;
    rst_n = 0;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, ls_gnt, ls_err, ls_rvalid, mem_req, mem_we, mem_be} !== '0 ||
        {if_rdata, ls_rdata, mem_addr, mem_wdata} !== '0)
      begin errors++; $display("FAIL midop_async gnt=%b/%b req=%b be=%h addr=%h exp=0", if_gnt, ls_gnt, mem_req, mem_be, mem_addr); end
    step(); step();
    ls_req = 0; if_req = 0;
    rst_n = 1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ls_rvalid || if_rvalid || mem_req) spurious = 1;
    end
    checks++;
    if (spurious !== 1'b0)
      begin errors++; $display("FAIL midop_spurious got=%b exp=0", spurious); end
    rv_delay = 0;
  endtask

  task automatic test_arbitration();
    int  cnt, n_gnt;
    bit  exp_if, got_own;
    gnt_delay = 0; rv_delay = 0; mem_word = 32'h0;
    cnt = 0; n_gnt = 0;
    ls_we = 0; ls_width = 2'b10; ls_addr = 32'h600; if_addr = 32'h700;
    ls_req = 1; if_req = 1;
    for (int i = 0; i < 400 && (n_gnt < 10 || own_q.size() > 0); i++) begin
      if (n_gnt >= 10) begin ls_req = 0; if_req = 0; end
      #1;
      if (ls_gnt || if_gnt) begin
`ifdef MEM_ARB_STARVE_EN
        exp_if = (cnt == STARVE_MAX);
`else
        exp_if = 1'b0;
`endif
        checks++;
        if (if_gnt !== exp_if || ls_gnt !== !exp_if)
          begin errors++; $display("FAIL arb_winner[%0d] if=%b ls=%b exp_if=%b", n_gnt, if_gnt, ls_gnt, exp_if); end
        own_q.push_back(!exp_if);
        cnt = exp_if ? 0 : cnt + 1;
        n_gnt++;
      end
      if (ls_rvalid || if_rvalid) begin
        checks++;
        got_own = own_q.pop_front();
        if (ls_rvalid !== got_own || if_rvalid !== !got_own)
          begin errors++; $display("FAIL arb_owner ls_rv=%b if_rv=%b exp_ls=%b", ls_rvalid, if_rvalid, got_own); end
      end
      step();
    end
    ls_req = 0; if_req = 0;
    checks++;
    if (n_gnt < 10 || own_q.size() != 0)
      begin errors++; $display("FAIL arb_timeout grants=%0d pending=%0d exp=10 0", n_gnt, own_q.size()); end
  endtask

  initial begin
    test_reset();
    test_load_path();
    test_store_path();
    test_misaligned();
    test_contention();
    test_reset_midop();
    test_arbitration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
